dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory target for the pipelined CPU's MEM stage, sitting at the far end of the CPU's data-memory interface (address, write enable, write data, transfer size, read data).
- Replaces the zero-latency data-memory model with a valid/ready request/response responder that has a configurable access latency and explicit error reporting.
- The CPU stalls its MEM stage against req_ready and resp_valid.

Parameters:
- DEPTH_BYTES, 1024: storage size in bytes; must be a power of two and a multiple of 8.
- LATENCY, 2: cycles from request acceptance to response valid; must be at least 1.
- ADDR_W, 64: request address width.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  64  store data; the low req_size bytes are used.
- req_size  input  4  transfer size in bytes; legal values 1, 2, 4, 8.
- resp_valid  output  1  response present.
- resp_ready  input  1  CPU accepts the response.
- resp_rdata  output  64  load data, zero-extended; 0 for stores and errors.
- resp_err  output  1  request was illegal (misaligned, out of range, or bad size).

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, reset_n).
- Reset (reset_n low at a clk edge):
  - state goes to IDLE; req_ready=0 during reset, 1 in the first cycle after release.
  - resp_valid=0, resp_rdata=0, resp_err=0; latency counter cleared.
  - Storage contents are NOT reset.
- FSM states: IDLE, BUSY, RESP. Only one request is outstanding at a time.
- IDLE:
  - req_ready=1.
  - On the edge where req_valid && req_ready: latch write, addr, wdata, size; counter=LATENCY-1; go to BUSY.
- BUSY:
  - req_ready=0.
  - Counter decrements each cycle.
  - On the edge where the counter is 0: perform the access and go to RESP. resp_valid rises exactly LATENCY cycles after the accept edge.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until the handshake.
  - On the edge where resp_ready=1: go to IDLE and clear resp_valid. The next request can be accepted no earlier than the following edge.
  - Minimum issue interval is therefore LATENCY+2 cycles.
- Access rules:
  - Byte addressing; big-endian, matching the existing datamem.
  - Byte at addr holds bits [8*size-1 : 8*size-8] of the datum.
  - Reads return the datum in resp_rdata[8*size-1:0], upper bits 0.
- Error conditions: size not in {1,2,4,8}; addr mod size != 0; addr+size > DEPTH_BYTES.
  - On error: no storage write; resp_rdata=0; resp_err=1; a response is still produced with normal latency.
- Stores: commit at the BUSY-to-RESP edge; resp_rdata=0.
- Reset during BUSY aborts the access with no write. Reset during RESP drops the pending response.
- Ignored inputs: req_* inputs are ignored outside IDLE; resp_ready is ignored outside RESP.
- Read-after-write: a load issued after a store's response returns the stored data.

Decomposition:
- Package cpu_mem_pkg:
  - enum resp_state_t {IDLE, BUSY, RESP}.
  - Size constants SZ_B=1, SZ_H=2, SZ_W=4, SZ_D=8.
  - Function legal_size().
- Sub-module dmem_byte_store:
  - Byte array with a one-cycle-registered 8-byte write port (per-byte enables) and a combinational 8-byte read port.
  - Handles the big-endian lane mapping.
- dmem_responder itself holds the FSM, latency counter, error check, and request/response registers.

Test Plan:
- Reset, then store size 8, addr 0x10, wdata 0x0123456789ABCDEF (LATENCY=2) -> resp_valid exactly 2 cycles after accept; resp_err=0; resp_rdata=0.
- Load size 8 at 0x10 -> resp_rdata=0x0123456789ABCDEF. Load size 1 at 0x10 -> 0x01. Load size 2 at 0x16 -> 0xCDEF.
- Load size 4 at 0x12 (misaligned) -> resp_err=1, resp_rdata=0. Store size 8 at DEPTH_BYTES-4 -> resp_err=1; a following load at 0x10 is still 0x0123456789ABCDEF.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable and req_ready=0 throughout; raising resp_ready returns to IDLE next edge.
- Store 0xFFFFFFFFFFFFFFFF to 0x20, assert reset_n=0 during BUSY -> no response; a load at 0x20 after reset returns the prior contents.
- Size 3 request -> resp_err=1. Back-to-back requests with req_valid held high -> second acceptance occurs exactly LATENCY+2 cycles after the first.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the CPU data-memory responder.
package cpu_mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} resp_state_t;

    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;
    localparam logic [3:0] SZ_D = 4'd8;

    function automatic logic legal_size(input logic [3:0] s);
        return (s == SZ_B) || (s == SZ_H) || (s == SZ_W) || (s == SZ_D);
    endfunction

endpackage

// File: rtl/dmem_byte_store.sv
// Byte-addressed storage with a registered 8-byte write port and a
// combinational 8-byte read port, both using big-endian lane order.
module dmem_byte_store #(
    parameter int DEPTH_BYTES = 1024,
    localparam int AW = $clog2(DEPTH_BYTES)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_size,
    input  logic [63:0]   i_wdata,
    output logic [63:0]   o_rdata
);

    logic [7:0]  r_mem [DEPTH_BYTES];
    logic [5:0]  w_sh;
    logic [63:0] w_wl;

    // Left-justify the datum so byte k of the access is always w_wl[63-8k -: 8].
    assign w_sh = {3'(4'd8 - i_size), 3'b000};
    assign w_wl = i_wdata << w_sh;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int k = 0; k < 8; k++) begin
                if (k < int'(i_size))
                    r_mem[i_addr + AW'(k)] <= w_wl[63-8*k -: 8];
            end
        end
    end

    // Shifting each byte in from the right yields the zero-extended big-endian datum.
    always_comb begin
        o_rdata = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < int'(i_size))
                o_rdata = {o_rdata[55:0], r_mem[i_addr + AW'(k)]};
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with fixed access latency and
// error reporting for misaligned, out-of-range and bad-size requests.
module dmem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2,
    parameter int ADDR_W      = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [3:0]        req_size,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              resp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    resp_state_t       r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_wdata;
    logic [3:0]        r_size;
    logic [63:0]       r_rdata;
    logic              r_err;

    logic              w_do_access;
    logic              w_misal;
    logic              w_oor;
    logic              w_err;
    logic [ADDR_W:0]   w_end;
    logic              w_we;
    logic [63:0]       w_rd;

    assign w_misal = (r_addr & ADDR_W'(r_size - 4'd1)) != '0;
    assign w_end   = {1'b0, r_addr} + (ADDR_W+1)'(r_size);
    assign w_oor   = w_end > (ADDR_W+1)'(DEPTH_BYTES);
    assign w_err   = !legal_size(r_size) || w_misal || w_oor;

    // Gating with reset_n keeps a reset on the final BUSY edge from committing the store.
    assign w_we = w_do_access && r_write && !w_err && reset_n;

    dmem_byte_store #(.DEPTH_BYTES(DEPTH_BYTES)) u_store (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_addr[AW-1:0]),
        .i_size  (r_size),
        .i_wdata (r_wdata),
        .o_rdata (w_rd)
    );

    always_comb begin
        w_next      = r_state;
        w_do_access = 1'b0;
        case (r_state)
            IDLE: if (req_valid) w_next = BUSY;
            BUSY: if (r_cnt == '0) begin
                w_next      = RESP;
                w_do_access = 1'b1;
            end
            RESP: if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req_valid) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_size  <= req_size;
                r_cnt   <= CW'(LATENCY - 1);
            end
            if (r_state == BUSY && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
            if (w_do_access) begin
                r_rdata <= (w_err || r_write) ? 64'd0 : w_rd;
                r_err   <= w_err;
            end
            if (r_state == RESP && resp_ready) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    assign req_ready  = reset_n && (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
